mnist_nn_hex_scan_driver: RTL and testbench
===========================================

Name: mnist_nn_hex_scan_driver

Overview:
Downstream consumer of the hex-digit PIO's 16-bit out_port. Drives a time-multiplexed 4-digit seven-segment display by showing one nibble per scan slot, with leading-zero blanking and a ghosting dead-time between digits. The displayed value is latched once per frame so the display never tears when software rewrites the PIO mid-scan.

Parameters:
DIGIT_CYCLES, 50000, clk cycles per digit slot (1 ms at 50 MHz); legal range >= 2
BLANK_CYCLES, 500, dead-time cycles at the start of each slot, all outputs off; legal range 0 <= BLANK_CYCLES < DIGIT_CYCLES
ACTIVE_LOW, 1, 1 = seg and dig_en pins are active-low; 0 = active-high
BLANK_LEADING_ZEROS, 1, 1 = suppress leading zero digits; 0 = show all four

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value_in  input  16  value from the PIO out_port; nibble [3:0] is digit 0 (rightmost)
enable  input  1  1 = scan; 0 = display dark
seg  output  7  segments: seg[0]=a … seg[6]=g
dig_en  output  4  digit select, one-hot when lit; bit k = digit k
frame_tick  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Internal state: slot counter c (0..DIGIT_CYCLES-1), digit index idx (0..3), 16-bit shadow register.
- c increments every cycle. At c==DIGIT_CYCLES-1, c wraps to 0 and idx increments; idx wraps from 3 to 0.
- Phase: BLANK when c < BLANK_CYCLES, otherwise SHOW.
- Frame start is the cycle where c==0 and idx==0. On that cycle:
  - shadow <= value_in.
  - frame_tick is driven high on the pins the next cycle, for exactly one cycle.
- Glyphs, active-high hex, bit6..0 = g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking applies only when BLANK_LEADING_ZEROS=1:
  - Digit k (k=1..3) is blank when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps dig_en inactive for the whole slot; slot timing is unchanged.
- Lit condition: SHOW phase and digit not blanked.
  - When lit: dig_en = one-hot(idx) and seg = glyph(shadow nibble idx).
  - Otherwise: dig_en = 0 and seg = 0 (logical values).
- Pin polarity: when ACTIVE_LOW=1, seg and dig_en are inverted at the pins. frame_tick is always active-high.
- All outputs are registered: pins lag the internal state by exactly 1 cycle.
- Reset, and also enable=0:
  - c=0, idx=0.
  - All seg/dig_en pins inactive (ACTIVE_LOW=1: seg=7F, dig_en=F).
  - frame_tick=0.
  - Reset additionally clears shadow to 0.
  - With enable=0, shadow is held.
- Resuming scan: the first cycle with enable=1 and reset=0 is a frame start (c=0, idx=0), so shadow is loaded then.
- Precedence: reset > enable=0 > normal scan.
- A value_in change mid-frame has no effect until the next frame start.
- Dead-time guarantee: dig_en never shows two bits active, and never changes directly from one digit to another without at least BLANK_CYCLES inactive cycles (when BLANK_CYCLES > 0).

Test Plan:
Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1, BLANK_LEADING_ZEROS=1, unless noted.
1. Assert reset for 3 cycles with value_in=1234 -> during reset and the first post-reset cycle: seg=7F, dig_en=F, frame_tick=0. Release -> frame_tick=1 exactly 1 cycle after release, then every 32 cycles.
2. value_in=1234 -> each slot: 2 cycles dig_en=F, then 6 cycles lit:
   - digit 0: dig_en=E, seg=19 ('4')
   - digit 1: dig_en=D, seg=30 ('3')
   - digit 2: dig_en=B, seg=24 ('2')
   - digit 3: dig_en=7, seg=79 ('1')
   - Sequence repeats with a 32-cycle period.
3. Leading-zero blanking:
   - value_in=0070 -> digits 3 and 2 stay dark (dig_en=F); digit 1 seg=78 ('7'); digit 0 seg=40 ('0').
   - value_in=0000 -> only digit 0 lights, seg=40.
   - Rerun with BLANK_LEADING_ZEROS=0 -> all four digits light with seg=40.
4. Mid-frame update: change value_in 1234->ABCD during the digit-1 slot -> digits 2 and 3 of that frame still show '2' and '1'; from the next frame_tick all digits show D, C, b, A (seg 21, 46, 03, 08).
5. Drop enable for 5 cycles mid-SHOW of digit 2 -> pins go dark 1 cycle later. On re-enable -> scan restarts at digit 0 BLANK phase, with frame_tick asserted 1 cycle after enable rises.
6. Assert reset mid-slot while value=ABCD -> all pins inactive. After release -> one frame showing the latched value_in, with no residual ABCD glyph unless value_in is still ABCD.

Source files
------------

// File: rtl/mnist_nn_hex_scan_driver_if.sv
// Bus between the hex-digit PIO side and the seven-segment scan driver.
// The master drives the value to display and the scan enable; the slave
// drives the display pins and the per-frame tick.
interface mnist_nn_hex_scan_driver_if;
  logic [15:0] value_in;
  logic        enable;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_tick;

  modport master (
    output value_in,
    output enable,
    input  seg,
    input  dig_en,
    input  frame_tick
  );

  modport slave (
    input  value_in,
    input  enable,
    output seg,
    output dig_en,
    output frame_tick
  );
endinterface

// File: rtl/mnist_nn_hex_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver for the hex-digit PIO.
// One nibble per scan slot, a dead-time at the start of every slot to avoid
// ghosting, optional leading-zero blanking, and a per-frame shadow copy of
// the value so a mid-scan rewrite never tears the displayed number.
module mnist_nn_hex_scan_driver #(
  parameter int DIGIT_CYCLES        = 50000,
  parameter int BLANK_CYCLES        = 500,
  parameter bit ACTIVE_LOW          = 1'b1,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  mnist_nn_hex_scan_driver_if.slave  bus
);

  localparam int            CW      = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    DIG_OFF = ACTIVE_LOW ? 4'hF : 4'h0;

  // Active-high hex glyph, bit6..0 = g..a.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [CW-1:0] c_q;
  logic [1:0]    idx_q;
  logic [15:0]   shadow_q;
  logic [6:0]    seg_q;
  logic [3:0]    dig_en_q;
  logic          frame_tick_q;

  logic          frame_start;
  logic [15:0]   shadow_eff;
  logic [3:0]    nibble;
  logic          lz_blank;
  logic          lit;
  logic [6:0]    seg_logic;
  logic [3:0]    dig_logic;
  logic [6:0]    seg_next;
  logic [3:0]    dig_next;

  // Decode the current slot into the pin values to register on this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    lz_blank  = 1'b0;
    seg_logic = 7'h00;
    dig_logic = 4'h0;

    frame_start = (c_q == '0) && (idx_q == 2'd0);
    // The value latched at frame start is already valid for digit 0 of that
    // frame, which matters when there is no dead-time.
    shadow_eff  = frame_start ? bus.value_in : shadow_q;
    nibble      = shadow_eff[{idx_q, 2'b00} +: 4];

    if (BLANK_LEADING_ZEROS) begin
      case (idx_q)
        2'd1:    lz_blank = (shadow_eff[15:4]  == 12'h000);
        2'd2:    lz_blank = (shadow_eff[15:8]  == 8'h00);
        2'd3:    lz_blank = (shadow_eff[15:12] == 4'h0);
        default: lz_blank = 1'b0;
      endcase
    end

    lit = (c_q >= BLANK_C) && !lz_blank;
    if (lit) begin
      seg_logic = glyph(nibble);
      dig_logic = 4'b0001 << idx_q;
    end

    seg_next = ACTIVE_LOW ? ~seg_logic : seg_logic;
    dig_next = ACTIVE_LOW ? ~dig_logic : dig_logic;
  end

  // Slot/digit counters, per-frame shadow capture and registered pins.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      c_q          <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      seg_q        <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else if (!bus.enable) begin
      // Dark and parked at frame start; shadow keeps the last frame's value.
      c_q          <= '0;
      idx_q        <= 2'd0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow_q <= bus.value_in;
      end
      frame_tick_q <= frame_start;
      seg_q        <= seg_next;
      dig_en_q     <= dig_next;
      if (c_q == LAST_C) begin
        c_q   <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_mnist_nn_hex_scan_driver.sv
// Bench for the hex scan driver: two instances (leading-zero blanking on and
// off) share stimulus; a time-based reference model predicts the pins.
module tb_mnist_nn_hex_scan_driver;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam logic [11:0] DARK = {7'h7F, 4'hF, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        enable = 1'b1;

  int checks = 0;
  int errors = 0;

  mnist_nn_hex_scan_driver_if bus_lz ();
  mnist_nn_hex_scan_driver_if bus_nz ();

  assign bus_lz.value_in = value;
  assign bus_lz.enable   = enable;
  assign bus_nz.value_in = value;
  assign bus_nz.enable   = enable;

  mnist_nn_hex_scan_driver #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b1)
  ) dut_lz (
    .clk(clk), .reset(reset), .bus(bus_lz)
  );

  mnist_nn_hex_scan_driver #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b0)
  ) dut_nz (
    .clk(clk), .reset(reset), .bus(bus_nz)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed enabled cycles since scan (re)start, and the
  // value captured at the start of the current frame.
  logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          running = 1'b0;
  int          t = 0;
  logic [15:0] frame_val = 16'h0000;
  logic [11:0] exp_lz, exp_nz;

  function automatic logic [11:0] expect_pins(int slot, int pos, logic [15:0] fv, bit lz, bit ft);
    logic [6:0] s;
    logic [3:0] d;
    bit blanked;
    s = 7'h00;
    d = 4'h0;
    blanked = lz && (slot > 0) && ((fv >> (4 * slot)) == 16'h0000);
    if (pos >= BC && !blanked) begin
      s = glyph_tab[fv[4*slot +: 4]];
      d = 4'b0001 << slot;
    end
    return {~s, ~d, ft};
  endfunction

  // Advance one clock: predict pins for the inputs now applied, then sample.
  task automatic tick();
    bit ft;
    if (reset) begin
      running = 1'b0;
      frame_val = 16'h0000;
      exp_lz = DARK;
      exp_nz = DARK;
    end else if (!enable) begin
      running = 1'b0;
      exp_lz = DARK;
      exp_nz = DARK;
    end else begin
      if (!running) begin
        running = 1'b1;
        t = 0;
      end
      ft = ((t % (4 * DC)) == 0);
      if (ft) frame_val = value;
      exp_lz = expect_pins((t / DC) % 4, t % DC, frame_val, 1'b1, ft);
      exp_nz = expect_pins((t / DC) % 4, t % DC, frame_val, 1'b0, ft);
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] v);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    value = v;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    value = 16'h1234;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick};
      checks++;
      if (got !== DARK) begin errors++; $display("FAIL reset_pins i=%0d got %h want %h", i, got, DARK); end
    end
    reset = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      tick();
      checks++;
      if (bus_lz.frame_tick !== ((i == 0) || (i == 32))) begin
        errors++; $display("FAIL reset_frame_tick i=%0d got %b", i, bus_lz.frame_tick);
      end
      checks++;
      if ({bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick} !== exp_nz) begin
        errors++; $display("FAIL reset_model_nz i=%0d got %h want %h", i, {bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick}, exp_nz);
      end
    end
  endtask

  task automatic test_scan_1234();
    logic [6:0]  lit_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0]  lit_dig [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [11:0] want;
    restart(16'h1234);
    for (int j = 0; j < 64; j++) begin
      tick();
      want = ((j % DC) < BC) ? {7'h7F, 4'hF, ((j % 32) == 0)}
                             : {lit_seg[(j / DC) % 4], lit_dig[(j / DC) % 4], 1'b0};
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== want) begin
        errors++; $display("FAIL scan_1234_lz j=%0d got %h want %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick}, want);
      end
      checks++;
      if ({bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick} !== want) begin
        errors++; $display("FAIL scan_1234_nz j=%0d got %h want %h", j, {bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick}, want);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [2] = '{16'h0070, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      restart(vals[k]);
      for (int j = 0; j < 32; j++) begin
        tick();
        checks++;
        if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== exp_lz) begin
          errors++; $display("FAIL lz_model_lz v=%h j=%0d got %h want %h", vals[k], j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick}, exp_lz);
        end
        checks++;
        if ({bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick} !== exp_nz) begin
          errors++; $display("FAIL lz_model_nz v=%h j=%0d got %h want %h", vals[k], j, {bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick}, exp_nz);
        end
        if (j == 12 && k == 0) begin
          checks++;
          if ({bus_lz.seg, bus_lz.dig_en} !== {7'h78, 4'hD}) begin errors++; $display("FAIL lz_digit1_seven got %h", {bus_lz.seg, bus_lz.dig_en}); end
        end
        if (j == 4) begin
          checks++;
          if ({bus_lz.seg, bus_lz.dig_en} !== {7'h40, 4'hE}) begin errors++; $display("FAIL lz_digit0_zero v=%h got %h", vals[k], {bus_lz.seg, bus_lz.dig_en}); end
        end
        if (j == 28) begin
          checks++;
          if (bus_lz.dig_en !== 4'hF) begin errors++; $display("FAIL lz_digit3_dark v=%h got %h", vals[k], bus_lz.dig_en); end
          checks++;
          if ({bus_nz.seg, bus_nz.dig_en} !== {7'h40, 4'h7}) begin errors++; $display("FAIL nz_digit3_zero v=%h got %h", vals[k], {bus_nz.seg, bus_nz.dig_en}); end
        end
      end
    end
  endtask

  task automatic test_mid_frame_update();
    restart(16'h1234);
    for (int j = 0; j < 64; j++) begin
      if (j == 10) value = 16'hABCD;
      tick();
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== exp_lz) begin
        errors++; $display("FAIL midframe_model j=%0d got %h want %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick}, exp_lz);
      end
      if (j == 20 || j == 28 || j == 36 || j == 44 || j == 52 || j == 60) begin
        checks++;
        case (j)
          20: if (bus_lz.seg !== 7'h24) begin errors++; $display("FAIL midframe_old_2 got %h want 24", bus_lz.seg); end
          28: if (bus_lz.seg !== 7'h79) begin errors++; $display("FAIL midframe_old_1 got %h want 79", bus_lz.seg); end
          36: if (bus_lz.seg !== 7'h21) begin errors++; $display("FAIL midframe_new_D got %h want 21", bus_lz.seg); end
          44: if (bus_lz.seg !== 7'h46) begin errors++; $display("FAIL midframe_new_C got %h want 46", bus_lz.seg); end
          52: if (bus_lz.seg !== 7'h03) begin errors++; $display("FAIL midframe_new_b got %h want 03", bus_lz.seg); end
          default: if (bus_lz.seg !== 7'h08) begin errors++; $display("FAIL midframe_new_A got %h want 08", bus_lz.seg); end
        endcase
      end
    end
  endtask

  task automatic test_enable_drop();
    restart(16'h1234);
    for (int j = 0; j < 20; j++) tick();
    enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== DARK) begin
        errors++; $display("FAIL enable_dark j=%0d got %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick});
      end
    end
    enable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (j == 0) begin
        checks++;
        if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== 12'hFFF) begin
          errors++; $display("FAIL enable_restart_tick got %h want fff", {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick});
        end
      end
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== exp_lz) begin
        errors++; $display("FAIL enable_model j=%0d got %h want %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick}, exp_lz);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    restart(16'hABCD);
    for (int j = 0; j < 13; j++) tick();
    reset = 1'b1;
    value = 16'h5678;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== DARK) begin
        errors++; $display("FAIL midreset_dark j=%0d got %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick});
      end
    end
    reset = 1'b0;
    for (int j = 0; j < 32; j++) begin
      tick();
      if (j == 4) begin
        checks++;
        if ({bus_lz.seg, bus_lz.dig_en} !== {7'h00, 4'hE}) begin
          errors++; $display("FAIL midreset_digit0_8 got %h want 00e", {bus_lz.seg, bus_lz.dig_en});
        end
      end
      checks++;
      if ({bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick} !== exp_nz) begin
        errors++; $display("FAIL midreset_model j=%0d got %h want %h", j, {bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick}, exp_nz);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  last_dig = 4'hF;
    int          dark_run = 0;
    logic [31:0] r;
    restart(16'h0001);
    for (int j = 0; j < 1500; j++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        value = r[15:0] >> (4 * $urandom_range(0, 3));
      end
      tick();
      checks++;
      if ({bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick} !== exp_lz) begin
        errors++; $display("FAIL random_lz j=%0d got %h want %h", j, {bus_lz.seg, bus_lz.dig_en, bus_lz.frame_tick}, exp_lz);
      end
      checks++;
      if ({bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick} !== exp_nz) begin
        errors++; $display("FAIL random_nz j=%0d got %h want %h", j, {bus_nz.seg, bus_nz.dig_en, bus_nz.frame_tick}, exp_nz);
      end
      if (bus_nz.dig_en === 4'hF) begin
        dark_run++;
      end else begin
        checks++;
        if ($countones(~bus_nz.dig_en) != 1 ||
            (last_dig != 4'hF && bus_nz.dig_en != last_dig && dark_run < BC)) begin
          errors++; $display("FAIL dead_time j=%0d dig_en %h prev %h gap %0d", j, bus_nz.dig_en, last_dig, dark_run);
        end
        last_dig = bus_nz.dig_en;
        dark_run = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_leading_zero();
    test_mid_frame_update();
    test_enable_drop();
    test_reset_mid_slot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
